// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round controller for a target-hitting game.
// A round is started from IDLE at one of three difficulty levels. The
// selected level sets the round length, counted in enabled cycles.
// During PLAY the per-target done flags accumulate into a sticky LED
// vector. The round is won when every LED is lit, and lost when the
// timer runs out or an external time_out abort arrives. A saturating
// win-streak counter is kept across rounds and cleared on any loss.
module game_round_ctrl #(
  parameter int NUM_LEDS = 3,
  parameter int TMR_W    = 16,
  parameter int T_NORMAL = 1000,
  parameter int T_INTER  = 600,
  parameter int T_ADV    = 300,
  parameter int SCORE_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          tog_start,
  input  logic                enable,
  input  logic                time_out,
  input  logic [NUM_LEDS-1:0] done,
  output logic [NUM_LEDS-1:0] LED,
  output logic                busy,
  output logic                win,
  output logic                lose,
  output logic [TMR_W-1:0]    time_left,
  output logic [SCORE_W-1:0]  score
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0]    LOAD_NORMAL = TMR_W'(T_NORMAL);
  localparam logic [TMR_W-1:0]    LOAD_INTER  = TMR_W'(T_INTER);
  localparam logic [TMR_W-1:0]    LOAD_ADV    = TMR_W'(T_ADV);
  localparam logic [TMR_W-1:0]    TMR_ONE     = TMR_W'(1);
  localparam logic [SCORE_W-1:0]  SCORE_MAX   = '1;
  localparam logic [NUM_LEDS-1:0] LED_ALL     = '1;

  state_t               state;
  state_t               next_state;

  logic [NUM_LEDS-1:0]  led_next;
  logic [TMR_W-1:0]     time_next;
  logic [SCORE_W-1:0]   score_next;

  logic [NUM_LEDS-1:0]  led_merged;
  logic                 start_ok;
  logic                 complete;
  logic                 expire;

  // Streak counter increment that sticks at all ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] val);
    sat_inc = (val == SCORE_MAX) ? SCORE_MAX : val + SCORE_W'(1);
  endfunction

  // Round length selected by the level code. The invalid code 10 never
  // reaches here because start is rejected for it.
  function automatic logic [TMR_W-1:0] level_load(input logic [1:0] lvl);
    case (lvl)
      2'b00:   level_load = LOAD_NORMAL;
      2'b01:   level_load = LOAD_INTER;
      default: level_load = LOAD_ADV;
    endcase
  endfunction

  // The timer is loaded once when the round starts, and that load is the
  // only place the level is latched. Later tog_start changes therefore
  // cannot affect a round that is already running.
  assign start_ok   = start && (tog_start != 2'b10);
  assign led_merged = LED | done;
  // Completion is checked before expiry and before abort, so a round that
  // finishes on its last enabled cycle still counts as a win.
  assign complete   = enable && (led_merged == LED_ALL);
  assign expire     = enable && (time_left == TMR_ONE);

  // State and registered outputs; reset forces everything to zero at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      LED       <= '0;
      time_left <= '0;
      score     <= '0;
      busy      <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      state     <= next_state;
      LED       <= led_next;
      time_left <= time_next;
      score     <= score_next;
      busy      <= (next_state == PLAY);
      win       <= (next_state == WIN);
      lose      <= (next_state == LOSE);
    end
  end

  // Next-state selection: completion beats abort, and abort beats timer expiry.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_ok) next_state = PLAY;
      end
      PLAY: begin
        if (complete)      next_state = WIN;
        else if (time_out) next_state = LOSE;
        else if (expire)   next_state = LOSE;
      end
      WIN, LOSE: begin
        if (start) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath next values for the LED vector, the round timer and the score.
  always_comb begin
    led_next   = LED;
    time_next  = time_left;
    score_next = score;
    case (state)
      IDLE: begin
        led_next  = '0;
        time_next = '0;
        if (start_ok) time_next = level_load(tog_start);
      end
      PLAY: begin
        if (complete) begin
          led_next   = led_merged;
          time_next  = time_left - TMR_ONE;
          score_next = sat_inc(score);
        end else if (time_out) begin
          // An abort freezes the display and the timer where they stand.
          score_next = '0;
        end else if (enable) begin
          led_next  = led_merged;
          time_next = time_left - TMR_ONE;
          if (expire) score_next = '0;
        end
      end
      WIN, LOSE: begin
        if (start) begin
          led_next  = '0;
          time_next = '0;
        end
      end
      default: begin
        led_next  = '0;
        time_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Testbench for game_round_ctrl: directed scenarios plus randomized play,
// all checked against a round-level reference model.
module tb_game_round_ctrl;

  localparam int NL = 3;
  localparam int TW = 16;
  localparam int TN = 1000;
  localparam int TI = 600;
  localparam int TA = 300;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    tog_start = 2'b00;
  logic          enable = 1'b0;
  logic          time_out = 1'b0;
  logic [NL-1:0] done = '0;
  logic [NL-1:0] LED;
  logic          busy, win, lose;
  logic [TW-1:0] time_left;
  logic [SW-1:0] score;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: round phase plus the values shown to the player.
  // Phase codes are 0 idle, 1 playing, 2 won, 3 lost.
  int m_phase = 0;
  int m_led   = 0;
  int m_time  = 0;
  int m_score = 0;

  game_round_ctrl #(
    .NUM_LEDS(NL), .TMR_W(TW), .T_NORMAL(TN), .T_INTER(TI), .T_ADV(TA), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tog_start(tog_start), .enable(enable),
    .time_out(time_out), .done(done), .LED(LED), .busy(busy), .win(win),
    .lose(lose), .time_left(time_left), .score(score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".busy"},  32'(busy),      32'(m_phase == 1));
    check({tag, ".win"},   32'(win),       32'(m_phase == 2));
    check({tag, ".lose"},  32'(lose),      32'(m_phase == 3));
    check({tag, ".led"},   32'(LED),       32'(m_led));
    check({tag, ".time"},  32'(time_left), 32'(m_time));
    check({tag, ".score"}, 32'(score),     32'(m_score));
  endtask

  // Round rules applied for one clock edge with the given inputs.
  task automatic model_step(input bit s, input int lvl, input bit en, input bit to, input int d);
    int all_lit;
    all_lit = (1 << NL) - 1;
    case (m_phase)
      0: begin
        if (s && lvl != 2) begin
          m_phase = 1;
          m_time  = (lvl == 0) ? TN : (lvl == 1) ? TI : TA;
        end
      end
      1: begin
        if (en && ((m_led | d) == all_lit)) begin
          m_phase = 2;
          m_led   = all_lit;
          m_time  = m_time - 1;
          if (m_score < (1 << SW) - 1) m_score = m_score + 1;
        end else if (to) begin
          m_phase = 3;
          m_score = 0;
        end else if (en) begin
          m_led  = m_led | d;
          m_time = m_time - 1;
          if (m_time == 0) begin
            m_phase = 3;
            m_score = 0;
          end
        end
      end
      default: begin
        if (s) begin
          m_phase = 0;
          m_led   = 0;
          m_time  = 0;
        end
      end
    endcase
  endtask

  task automatic cyc(input bit s, input int lvl, input bit en, input bit to, input int d,
                     input string tag);
    start     = s;
    tog_start = 2'(lvl);
    enable    = en;
    time_out  = to;
    done      = NL'(d);
    model_step(s, lvl, en, to, d);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset state
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Normal level, one target per cycle, win
    cyc(1, 0, 1, 0, 0, "n.start");
    check("n.loaded", 32'(time_left), TN);
    cyc(0, 0, 1, 0, 1, "n.d1");
    check("n.led1", 32'(LED), 1);
    cyc(0, 0, 1, 0, 2, "n.d2");
    check("n.led2", 32'(LED), 3);
    cyc(0, 0, 1, 0, 4, "n.d3");
    check("n.win", 32'(win), 1);
    check("n.tl", 32'(time_left), TN - 3);
    check("n.score", 32'(score), 1);
    cyc(1, 0, 0, 0, 0, "n.ack");

    // Advanced level, nothing done, timer expires after exactly TA cycles
    cyc(1, 3, 1, 0, 0, "a.start");
    for (int i = 0; i < TA - 1; i++) cyc(0, 3, 1, 0, 0, "a.run");
    check("a.still_busy", 32'(busy), 1);
    cyc(0, 3, 1, 0, 0, "a.last");
    check("a.lose", 32'(lose), 1);
    check("a.tl0", 32'(time_left), 0);
    check("a.score0", 32'(score), 0);
    cyc(1, 0, 0, 0, 0, "a.ack");

    // Last target lands on the final cycle: win beats expiry
    cyc(1, 3, 1, 0, 0, "e.start");
    cyc(0, 3, 1, 0, 1, "e.d1");
    for (int i = 0; i < TA - 2; i++) cyc(0, 3, 1, 0, 0, "e.run");
    check("e.tl1", 32'(time_left), 1);
    cyc(0, 1, 1, 1, 6, "e.final");
    check("e.win", 32'(win), 1);
    check("e.nolose", 32'(lose), 0);
    check("e.tl0", 32'(time_left), 0);
    cyc(1, 0, 0, 0, 0, "e.ack");

    // Enable low freezes progress; time_out still aborts
    cyc(1, 1, 1, 0, 0, "f.start");
    cyc(0, 1, 1, 0, 1, "f.d1");
    for (int i = 0; i < 50; i++) cyc(0, 2 * (i % 2), 0, 0, int'($urandom_range(0, 7)), "f.frozen");
    check("f.led", 32'(LED), 1);
    check("f.tl", 32'(time_left), TI - 1);
    cyc(1, 0, 0, 1, 0, "f.abort");
    check("f.lose", 32'(lose), 1);
    check("f.tlhold", 32'(time_left), TI - 1);
    cyc(1, 0, 0, 0, 0, "f.ack");

    // Invalid level code is ignored
    cyc(1, 2, 1, 0, 0, "i.start");
    check("i.busy", 32'(busy), 0);

    // Reset between clock edges in the middle of a round
    cyc(1, 0, 1, 0, 0, "r.start");
    cyc(0, 0, 1, 0, 2, "r.d");
    #3;
    rst = 1'b1;
    #1;
    m_phase = 0; m_led = 0; m_time = 0; m_score = 0;
    check_all("r.async");
    #1;
    rst = 1'b0;
    cyc(0, 0, 1, 0, 0, "r.after");

    // Win streak saturates, then a loss clears it
    for (int k = 0; k < 256; k++) begin
      cyc(1, 0, 1, 0, 0, "s.start");
      cyc(0, 0, 1, 0, 7, "s.win");
      cyc(1, 0, 0, 0, 0, "s.ack");
    end
    check("s.sat", 32'(score), 255);
    cyc(1, 3, 1, 0, 0, "s.lstart");
    cyc(0, 3, 1, 1, 0, "s.abort");
    check("s.cleared", 32'(score), 0);
    cyc(1, 0, 0, 0, 0, "s.ack2");

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      bit s, en, to;
      int lvl, d;
      s   = ($urandom_range(0, 99) < 8);
      lvl = int'($urandom_range(0, 3));
      en  = ($urandom_range(0, 99) < 80);
      to  = ($urandom_range(0, 999) < 3);
      d   = ($urandom_range(0, 99) < 4) ? int'($urandom_range(0, 7)) : 0;
      cyc(s, lvl, en, to, d, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 3: width of done/LED progress vector, 1..16.
REQ-002 SHALL have parameter TMR_W, default 16: width of round timer.
REQ-003 SHALL have parameters T_NORMAL, T_INTER, T_ADV, defaults 1000, 600, 300: round length in enabled cycles, each nonzero and below 2^TMR_W.
REQ-004 SHALL have parameter SCORE_W, default 8: width of win-streak counter.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  round start / acknowledge strobe, sampled on posedge clk.
REQ-008 tog_start  input  2  level select: 00 normal, 01 intermediate, 11 advanced, 10 invalid.
REQ-009 enable  input  1  play qualifier; 0 freezes timer and progress.
REQ-010 time_out  input  1  external abort; 1 in PLAY forces loss.
REQ-011 done  input  NUM_LEDS  per-target completion flags from player logic.
REQ-012 LED  output  NUM_LEDS  sticky progress display.
REQ-013 busy, win, lose  output  1 each  state flags (PLAY, WIN, LOSE).
REQ-014 time_left  output  TMR_W  remaining enabled cycles in round.
REQ-015 score  output  SCORE_W  consecutive wins.

Function
REQ-016 SHALL implement FSM states IDLE, PLAY, WIN, LOSE; busy/win/lose are registered decodes of PLAY/WIN/LOSE.
REQ-017 IDLE: LED=0, time_left=0; start=1 with tog_start in {00,01,11} -> PLAY next edge, latch level, load time_left with T_NORMAL/T_INTER/T_ADV; tog_start=10 -> start ignored, stay IDLE.
REQ-018 Latched level SHALL be held for the whole round; tog_start changes during PLAY have no effect.
REQ-019 PLAY, enable=1: LED <= LED | done; time_left <= time_left-1.
REQ-020 PLAY, enable=0: LED, time_left unchanged; time_out still honoured.
REQ-021 PLAY, enable=1 and (LED|done) all ones -> WIN next edge; score <= score+1, saturating at all ones.
REQ-022 PLAY, enable=1, time_left==1, not completing -> LOSE next edge with time_left=0; round thus lasts exactly T enabled cycles.
REQ-023 PLAY, time_out=1 and not completing -> LOSE next edge regardless of enable; time_left holds.
REQ-024 Simultaneous completion and timer expiry or time_out in same enabled cycle SHALL resolve to WIN.
REQ-025 start during PLAY SHALL be ignored.
REQ-026 WIN/LOSE: LED and time_left hold final values; start=1 -> IDLE next edge (LED, time_left cleared).
REQ-027 Entry to LOSE SHALL clear score to 0 on same edge.
REQ-028 Latency: start at edge N -> busy=1 after N; final completing done at edge M -> win=1 and score updated after M.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, LED=0, busy=win=lose=0, time_left=0, score=0, independent of clk.
REQ-030 rst asserted mid-round SHALL abandon the round with no score change beyond clearing; first edge after deassertion evaluates IDLE rules.

Verification
REQ-031 NUM_LEDS=3, tog_start=00, start pulse, enable=1, done=001,010,100 on successive cycles -> LED 001,011,111, win=1, score=1, time_left=T_NORMAL-3.
REQ-032 tog_start=11, start, enable=1, done=000 -> LOSE after exactly T_ADV cycles, time_left=0, lose=1, score=0.
REQ-033 Last done bit arrives on cycle where time_left==1 -> win=1, lose=0, time_left=0.
REQ-034 PLAY with enable=0 for 50 cycles, done toggling -> LED and time_left unchanged; time_out=1 -> lose=1 next cycle.
REQ-035 tog_start=10 with start -> stays IDLE, busy=0; rst pulse mid-PLAY between clock edges -> outputs zero immediately.
REQ-036 Win 255 rounds then one more with SCORE_W=8 -> score stays 255; subsequent loss -> score=0.
